// File: rtl/tdr_pkg.sv
// Shared types and default widths for the TDR acquisition controller.
package tdr_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int IDX_W_DEF  = 12;
    localparam int SHOT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT,
        CAPT,
        HOLD,
        DONE
    } acq_state_t;

endpackage

// File: rtl/tdr_acq_ctrl_if.sv
// Host/pulse_gen/capture-buffer signal bundle around the acquisition controller.
// The master modport is the controller side; the slave modport is its environment.
interface tdr_acq_ctrl_if
    import tdr_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SHOT_W = SHOT_W_DEF
) ();

    logic              start;
    logic              abort;
    logic [SHOT_W-1:0] cfg_shots;
    logic [CNT_W-1:0]  cfg_delay;
    logic [IDX_W-1:0]  cfg_window;
    logic [CNT_W-1:0]  cfg_holdoff;
    logic              cap_ready;
    logic              trig_out;
    logic              pulse_en;
    logic              cap_valid;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_last;
    logic [SHOT_W-1:0] shot_idx;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        input  start, abort, cfg_shots, cfg_delay, cfg_window, cfg_holdoff, cap_ready,
        output trig_out, pulse_en, cap_valid, cap_idx, cap_last, shot_idx, busy, done, aborted
    );

    modport slave (
        output start, abort, cfg_shots, cfg_delay, cfg_window, cfg_holdoff, cap_ready,
        input  trig_out, pulse_en, cap_valid, cap_idx, cap_last, shot_idx, busy, done, aborted
    );

endinterface

// File: rtl/tdr_load_dcnt.sv
// Loadable down-counter that saturates at zero and flags the values 0 and 1.
// The "one" flag lets the owner act a cycle ahead of the count reaching zero.
module tdr_load_dcnt
    import tdr_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Load has priority over decrement; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/tdr_acq_ctrl.sv
// Sequences one TDR acquisition burst: per shot it arms on cap_ready, fires a
// one-cycle trigger, waits the pulse delay, strobes a capture window and then
// holds off. All outputs are registered. rst is expected to be released
// synchronously to clk by the surrounding reset logic.
module tdr_acq_ctrl
    import tdr_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SHOT_W = SHOT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    tdr_acq_ctrl_if.master bus
);

    acq_state_t        state_d, state_q;
    logic [SHOT_W-1:0] shots_d, shots_q;
    logic [CNT_W-1:0]  delay_d, delay_q;
    logic [IDX_W-1:0]  window_d, window_q;
    logic [CNT_W-1:0]  holdoff_d, holdoff_q;
    logic [SHOT_W-1:0] shot_idx_d, shot_idx_q;
    logic [IDX_W-1:0]  cap_idx_d, cap_idx_q;
    logic              trig_d, trig_q;
    logic              cap_valid_d, cap_valid_q;
    logic              cap_last_d, cap_last_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              aborted_d, aborted_q;

    logic              go_capt;
    logic              dly_load, dly_dec, dly_zero, dly_one;
    logic [CNT_W-1:0]  dly_val;
    logic              win_load, win_dec, win_zero, win_one;
    logic [IDX_W-1:0]  win_val;

    // Delay and holdoff never overlap, so they share one counter.
    tdr_load_dcnt #(.W(CNT_W)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .dec      (dly_dec),
        .zero     (dly_zero),
        .one      (dly_one)
    );

    // Remaining strobes in the current capture window.
    tdr_load_dcnt #(.W(IDX_W)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (win_val),
        .dec      (win_dec),
        .zero     (win_zero),
        .one      (win_one)
    );

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        shots_d     = shots_q;
        delay_d     = delay_q;
        window_d    = window_q;
        holdoff_d   = holdoff_q;
        shot_idx_d  = shot_idx_q;
        cap_idx_d   = cap_idx_q;
        trig_d      = 1'b0;
        cap_valid_d = 1'b0;
        cap_last_d  = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        go_capt     = 1'b0;
        dly_load    = 1'b0;
        dly_val     = '0;
        dly_dec     = 1'b0;
        win_load    = 1'b0;
        win_val     = '0;
        win_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    shots_d    = bus.cfg_shots;
                    delay_d    = bus.cfg_delay;
                    window_d   = bus.cfg_window;
                    holdoff_d  = bus.cfg_holdoff;
                    shot_idx_d = '0;
                    cap_idx_d  = '0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (shots_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (bus.cap_ready) begin
                    state_d = FIRE;
                    trig_d  = 1'b1;
                end
            end
            FIRE: begin
                if (delay_q == '0) begin
                    go_capt = 1'b1;
                end else begin
                    state_d  = WAIT;
                    dly_load = 1'b1;
                    dly_val  = delay_q;
                end
            end
            WAIT: begin
                if (dly_one) begin
                    go_capt = 1'b1;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            CAPT: begin
                if (win_zero) begin
                    state_d  = HOLD;
                    dly_load = 1'b1;
                    dly_val  = holdoff_q;
                end else begin
                    win_dec     = 1'b1;
                    cap_valid_d = 1'b1;
                    cap_idx_d   = cap_idx_q + IDX_W'(1);
                    cap_last_d  = win_one;
                end
            end
            HOLD: begin
                if (!dly_zero) begin
                    dly_dec = 1'b1;
                end else if (shot_idx_q == (shots_q - SHOT_W'(1))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    shot_idx_d = shot_idx_q + SHOT_W'(1);
                    state_d    = ARM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_capt) begin
            state_d     = CAPT;
            cap_valid_d = 1'b1;
            cap_idx_d   = '0;
            cap_last_d  = (window_q <= IDX_W'(1));
            win_load    = 1'b1;
            win_val     = (window_q == '0) ? '0 : (window_q - IDX_W'(1));
        end

        if (bus.abort && (state_q inside {ARM, FIRE, WAIT, CAPT, HOLD})) begin
            state_d     = DONE;
            done_d      = 1'b1;
            aborted_d   = 1'b1;
            trig_d      = 1'b0;
            cap_valid_d = 1'b0;
            cap_last_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, shadow configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shots_q     <= '0;
            delay_q     <= '0;
            window_q    <= '0;
            holdoff_q   <= '0;
            shot_idx_q  <= '0;
            cap_idx_q   <= '0;
            trig_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shots_q     <= shots_d;
            delay_q     <= delay_d;
            window_q    <= window_d;
            holdoff_q   <= holdoff_d;
            shot_idx_q  <= shot_idx_d;
            cap_idx_q   <= cap_idx_d;
            trig_q      <= trig_d;
            cap_valid_q <= cap_valid_d;
            cap_last_q  <= cap_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.trig_out  = trig_q;
    assign bus.pulse_en  = busy_q;
    assign bus.cap_valid = cap_valid_q;
    assign bus.cap_idx   = cap_idx_q;
    assign bus.cap_last  = cap_last_q;
    assign bus.shot_idx  = shot_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_tdr_acq_ctrl.sv
// Directed bench for tdr_acq_ctrl: single shot, multi-shot spacing, cap_ready
// stall, abort mid-window, empty burst, start+abort in IDLE and reset mid-burst.
module tb_tdr_acq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    tdr_acq_ctrl_if bus ();

    tdr_acq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] shots, input logic [15:0] delay,
                                 input logic [11:0] window, input logic [15:0] holdoff);
        bus.cfg_shots   = shots;
        bus.cfg_delay   = delay;
        bus.cfg_window  = window;
        bus.cfg_holdoff = holdoff;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Linear directed sequence; every expected value is hand-derived from the burst timing.
    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cap_ready = 1'b0;
        applyStimulus(8'd0, 16'd0, 12'd0, 16'd0);
        tick();
        tick();

        checkOutput("rst_trig",     32'(bus.trig_out),  32'd0);
        checkOutput("rst_busy",     32'(bus.busy),      32'd0);
        checkOutput("rst_pulse_en", 32'(bus.pulse_en),  32'd0);
        checkOutput("rst_valid",    32'(bus.cap_valid), 32'd0);
        checkOutput("rst_last",     32'(bus.cap_last),  32'd0);
        checkOutput("rst_cap_idx",  32'(bus.cap_idx),   32'd0);
        checkOutput("rst_shot_idx", 32'(bus.shot_idx),  32'd0);
        checkOutput("rst_done",     32'(bus.done),      32'd0);
        checkOutput("rst_aborted",  32'(bus.aborted),   32'd0);
        rst = 1'b0;
        tick();

        // Single shot, zero delay, window 4, no holdoff.
        bus.cap_ready = 1'b1;
        applyStimulus(8'd1, 16'd0, 12'd4, 16'd0);
        pulseStart();
        checkOutput("t1_arm_busy",  32'(bus.busy),     32'd1);
        checkOutput("t1_arm_pen",   32'(bus.pulse_en), 32'd1);
        checkOutput("t1_arm_trig",  32'(bus.trig_out), 32'd0);
        tick();
        checkOutput("t1_fire_trig", 32'(bus.trig_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t1_capt_valid", 32'(bus.cap_valid), 32'd1);
            checkOutput("t1_capt_idx",   32'(bus.cap_idx),   32'(i));
            checkOutput("t1_capt_last",  32'(bus.cap_last),  32'(i == 3));
            checkOutput("t1_capt_trig",  32'(bus.trig_out),  32'd0);
        end
        tick();
        checkOutput("t1_hold_valid", 32'(bus.cap_valid), 32'd0);
        checkOutput("t1_hold_done",  32'(bus.done),      32'd0);
        tick();
        checkOutput("t1_done",       32'(bus.done),      32'd1);
        checkOutput("t1_aborted",    32'(bus.aborted),   32'd0);
        tick();
        checkOutput("t1_idle_done",  32'(bus.done),      32'd0);
        checkOutput("t1_idle_busy",  32'(bus.busy),      32'd0);

        // Three shots, delay 2, window 2, holdoff 5; cfg changes and start mid-burst ignored.
        applyStimulus(8'd3, 16'd2, 12'd2, 16'd5);
        pulseStart();
        checkOutput("t2_arm_busy", 32'(bus.busy), 32'd1);
        applyStimulus(8'd1, 16'd0, 12'd9, 16'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput("t2_fire_trig", 32'(bus.trig_out), 32'd1);
            checkOutput("t2_fire_shot", 32'(bus.shot_idx), 32'(s));
            if (s == 0) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            checkOutput("t2_wait1_trig",  32'(bus.trig_out),  32'd0);
            checkOutput("t2_wait1_valid", 32'(bus.cap_valid), 32'd0);
            tick();
            checkOutput("t2_wait2_valid", 32'(bus.cap_valid), 32'd0);
            tick();
            checkOutput("t2_c0_valid", 32'(bus.cap_valid), 32'd1);
            checkOutput("t2_c0_idx",   32'(bus.cap_idx),   32'd0);
            checkOutput("t2_c0_last",  32'(bus.cap_last),  32'd0);
            tick();
            checkOutput("t2_c1_valid", 32'(bus.cap_valid), 32'd1);
            checkOutput("t2_c1_idx",   32'(bus.cap_idx),   32'd1);
            checkOutput("t2_c1_last",  32'(bus.cap_last),  32'd1);
            for (int h = 0; h < 6; h++) begin
                tick();
                checkOutput("t2_hold_valid", 32'(bus.cap_valid), 32'd0);
                checkOutput("t2_hold_trig",  32'(bus.trig_out),  32'd0);
                checkOutput("t2_hold_done",  32'(bus.done),      32'd0);
            end
            if (s < 2) begin
                tick();
                checkOutput("t2_arm_trig", 32'(bus.trig_out), 32'd0);
                checkOutput("t2_arm_shot", 32'(bus.shot_idx), 32'(s + 1));
            end
        end
        tick();
        checkOutput("t2_done",      32'(bus.done),     32'd1);
        checkOutput("t2_aborted",   32'(bus.aborted),  32'd0);
        checkOutput("t2_done_shot", 32'(bus.shot_idx), 32'd2);
        tick();
        checkOutput("t2_idle_busy", 32'(bus.busy),     32'd0);
        checkOutput("t2_idle_done", 32'(bus.done),     32'd0);

        // cap_ready held low for 10 cycles; window 0 behaves as window 1.
        applyStimulus(8'd1, 16'd1, 12'd0, 16'd0);
        bus.cap_ready = 1'b0;
        pulseStart();
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t3_stall_trig", 32'(bus.trig_out), 32'd0);
            checkOutput("t3_stall_busy", 32'(bus.busy),     32'd1);
        end
        bus.cap_ready = 1'b1;
        tick();
        checkOutput("t3_fire_trig", 32'(bus.trig_out),  32'd1);
        tick();
        checkOutput("t3_wait_valid", 32'(bus.cap_valid), 32'd0);
        tick();
        checkOutput("t3_capt_valid", 32'(bus.cap_valid), 32'd1);
        checkOutput("t3_capt_idx",   32'(bus.cap_idx),   32'd0);
        checkOutput("t3_capt_last",  32'(bus.cap_last),  32'd1);
        tick();
        checkOutput("t3_hold_valid", 32'(bus.cap_valid), 32'd0);
        tick();
        checkOutput("t3_done",       32'(bus.done),      32'd1);
        tick();
        checkOutput("t3_idle_busy",  32'(bus.busy),      32'd0);

        // Abort in CAPT at cap_idx 1 of a 4-strobe window.
        applyStimulus(8'd2, 16'd0, 12'd4, 16'd0);
        pulseStart();
        tick();
        checkOutput("t4_fire_trig", 32'(bus.trig_out), 32'd1);
        tick();
        tick();
        checkOutput("t4_idx1_valid", 32'(bus.cap_valid), 32'd1);
        checkOutput("t4_idx1_idx",   32'(bus.cap_idx),   32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("t4_ab_valid",   32'(bus.cap_valid), 32'd0);
        checkOutput("t4_ab_last",    32'(bus.cap_last),  32'd0);
        checkOutput("t4_ab_done",    32'(bus.done),      32'd1);
        checkOutput("t4_ab_aborted", 32'(bus.aborted),   32'd1);
        checkOutput("t4_ab_trig",    32'(bus.trig_out),  32'd0);
        tick();
        checkOutput("t4_idle_busy",    32'(bus.busy),    32'd0);
        checkOutput("t4_idle_done",    32'(bus.done),    32'd0);
        checkOutput("t4_idle_aborted", 32'(bus.aborted), 32'd0);

        // Empty burst, then start and abort together in IDLE.
        applyStimulus(8'd0, 16'd3, 12'd3, 16'd3);
        pulseStart();
        checkOutput("t5_arm_busy", 32'(bus.busy),     32'd1);
        checkOutput("t5_arm_trig", 32'(bus.trig_out), 32'd0);
        tick();
        checkOutput("t5_done",      32'(bus.done),     32'd1);
        checkOutput("t5_aborted",   32'(bus.aborted),  32'd0);
        checkOutput("t5_done_trig", 32'(bus.trig_out), 32'd0);
        tick();
        checkOutput("t5_idle_busy", 32'(bus.busy), 32'd0);
        applyStimulus(8'd1, 16'd0, 12'd1, 16'd0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("t5_sa_busy", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("t5_sa_busy2", 32'(bus.busy),     32'd0);
        checkOutput("t5_sa_done",  32'(bus.done),     32'd0);
        checkOutput("t5_sa_trig",  32'(bus.trig_out), 32'd0);

        // Reset asserted in HOLD of the second shot, then a clean burst.
        applyStimulus(8'd3, 16'd0, 12'd1, 16'd3);
        pulseStart();
        tick();
        checkOutput("t6_fire0_trig", 32'(bus.trig_out), 32'd1);
        tick();
        for (int h = 0; h < 4; h++) tick();
        tick();
        checkOutput("t6_arm1_shot", 32'(bus.shot_idx), 32'd1);
        tick();
        checkOutput("t6_fire1_trig", 32'(bus.trig_out), 32'd1);
        tick();
        tick();
        checkOutput("t6_hold_busy",  32'(bus.busy),      32'd1);
        checkOutput("t6_hold_shot",  32'(bus.shot_idx),  32'd1);
        checkOutput("t6_hold_valid", 32'(bus.cap_valid), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_busy",  32'(bus.busy),      32'd0);
        checkOutput("t6_rst_pen",   32'(bus.pulse_en),  32'd0);
        checkOutput("t6_rst_shot",  32'(bus.shot_idx),  32'd0);
        checkOutput("t6_rst_done",  32'(bus.done),      32'd0);
        checkOutput("t6_rst_trig",  32'(bus.trig_out),  32'd0);
        checkOutput("t6_rst_valid", 32'(bus.cap_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t6_post_done", 32'(bus.done), 32'd0);
        checkOutput("t6_post_busy", 32'(bus.busy), 32'd0);
        applyStimulus(8'd1, 16'd0, 12'd2, 16'd0);
        pulseStart();
        tick();
        checkOutput("t6_re_trig", 32'(bus.trig_out), 32'd1);
        checkOutput("t6_re_shot", 32'(bus.shot_idx), 32'd0);
        tick();
        checkOutput("t6_re_c0_idx",  32'(bus.cap_idx),  32'd0);
        checkOutput("t6_re_c0_last", 32'(bus.cap_last), 32'd0);
        tick();
        checkOutput("t6_re_c1_idx",  32'(bus.cap_idx),  32'd1);
        checkOutput("t6_re_c1_last", 32'(bus.cap_last), 32'd1);
        tick();
        checkOutput("t6_re_hold_valid", 32'(bus.cap_valid), 32'd0);
        tick();
        checkOutput("t6_re_done",    32'(bus.done),    32'd1);
        checkOutput("t6_re_aborted", 32'(bus.aborted), 32'd0);
        tick();
        checkOutput("t6_re_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
